// File: rtl/redirect_unit.sv
// Control-transfer resolver beside EX: turns resolved branches/jumps and trap requests
// into a PC write plus pipeline flush, holding the redirect while the PC register is stalled.
module redirect_unit #(
  parameter logic [3:0] FLUSH_BRANCH = 4'b0011,
  parameter logic [3:0] FLUSH_TRAP   = 4'b0111,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic             ex_taken,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_rs1,
  input  logic             trap_valid,
  input  logic [31:0]      trap_vector,
  input  logic             pc_stall,
  output logic             pc_w_enable,
  output logic [31:0]      pc_data,
  output logic [3:0]       flush_req,
  output logic             stall_req,
  output logic [31:0]      link_data,
  output logic             misalign_error,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic {IDLE, PENDING} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pend_target_q, pend_target_d;
  logic             pend_trap_q, pend_trap_d;
  logic             misalign_error_q, misalign_error_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]      cand_target;
  logic             cand_redir;
  logic             ex_req;
  logic             ex_misalign;
  logic             consume;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Candidate target: jalr > jal > taken branch; not-taken branches are predicted correctly
  always_comb begin
    cand_target = '0;
    cand_redir  = 1'b0;
    if (ex_is_jalr) begin
      cand_target = (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
      cand_redir  = 1'b1;
    end else if (ex_is_jal) begin
      cand_target = ex_pc + ex_imm;
      cand_redir  = 1'b1;
    end else if (ex_is_branch && ex_taken) begin
      cand_target = ex_pc + ex_imm;
      cand_redir  = 1'b1;
    end
  end

  assign ex_req      = ex_valid && cand_redir && (cand_target[1:0] == 2'b00);
  assign ex_misalign = ex_valid && cand_redir && (cand_target[1:0] != 2'b00);

  always_comb begin
    state_d          = state_q;
    pend_target_d    = pend_target_q;
    pend_trap_d      = pend_trap_q;
    misalign_error_d = 1'b0;
    pc_w_enable      = 1'b0;
    pc_data          = '0;
    flush_req        = '0;
    consume          = 1'b0;
    case (state_q)
      IDLE: begin
        // A trap flushes the faulting EX instruction, so its misalignment is moot
        misalign_error_d = ex_misalign && !trap_valid;
        if (trap_valid || ex_req) begin
          pc_w_enable = 1'b1;
          pc_data     = trap_valid ? trap_vector : cand_target;
          flush_req   = trap_valid ? FLUSH_TRAP : FLUSH_BRANCH;
          if (pc_stall) begin
            pend_target_d = pc_data;
            pend_trap_d   = trap_valid;
            state_d       = PENDING;
          end else begin
            consume = 1'b1;
          end
        end
      end
      PENDING: begin
        // EX now holds a younger, flushed instruction; only a trap may override
        pend_target_d = trap_valid ? trap_vector : pend_target_q;
        pend_trap_d   = trap_valid | pend_trap_q;
        pc_w_enable   = 1'b1;
        pc_data       = pend_target_d;
        flush_req     = pend_trap_d ? FLUSH_TRAP : FLUSH_BRANCH;
        if (!pc_stall) begin
          consume = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cnt_d = consume ? sat_inc(cnt_q) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      pend_target_q    <= '0;
      pend_trap_q      <= 1'b0;
      misalign_error_q <= 1'b0;
      cnt_q            <= '0;
    end else begin
      state_q          <= state_d;
      pend_target_q    <= pend_target_d;
      pend_trap_q      <= pend_trap_d;
      misalign_error_q <= misalign_error_d;
      cnt_q            <= cnt_d;
    end
  end

  assign stall_req      = 1'b0;
  assign link_data      = ex_pc + 32'd4;
  assign misalign_error = misalign_error_q;
  assign redirect_count = cnt_q;

endmodule

// File: tb/tb_redirect_unit.sv
// Scoreboard bench for redirect_unit: expected fetch-port values are queued as stimulus
// is applied and popped when the combinational outputs are sampled mid-cycle.
module tb_redirect_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_taken;
  logic [31:0] ex_pc, ex_imm, ex_rs1, trap_vector;
  logic        trap_valid, pc_stall;
  logic        pc_w_enable, stall_req, misalign_error;
  logic [31:0] pc_data, link_data;
  logic [3:0]  flush_req;
  logic [15:0] redirect_count;

  always #5 clk = ~clk;

  redirect_unit dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr), .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .trap_valid(trap_valid), .trap_vector(trap_vector),
    .pc_stall(pc_stall), .pc_w_enable(pc_w_enable), .pc_data(pc_data),
    .flush_req(flush_req), .stall_req(stall_req), .link_data(link_data),
    .misalign_error(misalign_error), .redirect_count(redirect_count)
  );

  typedef struct packed {logic en; logic [31:0] data; logic [3:0] flush;} exp_t;
  exp_t        exp_q[$];
  exp_t        e;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_cnt = '0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0; ex_taken = 0;
    ex_pc = 0; ex_imm = 0; ex_rs1 = 0; trap_valid = 0; trap_vector = 0; pc_stall = 0;
  endtask

  task automatic push(input logic en, input logic [31:0] d, input logic [3:0] f);
    exp_q.push_back({en, d, f});
  endtask

  task automatic test_reset();
    rst = 1; clr();
    tick(); tick();
    push(0, 32'h0, 4'h0);
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if ({pc_w_enable, pc_data, flush_req} !== e) begin
      miscompares++; $display("FAIL reset_out: got %h want %h", {pc_w_enable, pc_data, flush_req}, e);
    end
    vectors++;
    if ({redirect_count, misalign_error, stall_req} !== 18'h0) begin
      miscompares++; $display("FAIL reset_regs: got cnt=%h mis=%b stall=%b want 0", redirect_count, misalign_error, stall_req);
    end
    tick(); rst = 0;
  endtask

  task automatic test_branch();
    ex_valid = 1; ex_is_branch = 1; ex_taken = 1; ex_pc = 32'h100; ex_imm = 32'h20;
    push(1, 32'h120, 4'b0011);
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if ({pc_w_enable, pc_data, flush_req} !== e) begin
      miscompares++; $display("FAIL br_taken: got %h want %h", {pc_w_enable, pc_data, flush_req}, e);
    end
    tick(); exp_cnt++; clr();
    push(0, 32'h0, 4'h0);
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if ({pc_w_enable, pc_data, flush_req, redirect_count} !== {e, exp_cnt}) begin
      miscompares++; $display("FAIL br_after: got %h/%h want %h/%h", {pc_w_enable, pc_data, flush_req}, redirect_count, e, exp_cnt);
    end
    tick();
    ex_valid = 1; ex_is_branch = 1; ex_taken = 0; ex_pc = 32'h100; ex_imm = 32'h20;
    push(0, 32'h0, 4'h0);
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if ({pc_w_enable, pc_data, flush_req} !== e) begin
      miscompares++; $display("FAIL br_not_taken: got %h want %h", {pc_w_enable, pc_data, flush_req}, e);
    end
    tick(); clr();
    @(negedge clk); vectors++;
    if ({redirect_count, misalign_error} !== {exp_cnt, 1'b0}) begin
      miscompares++; $display("FAIL br_nt_cnt: got %h/%b want %h/0", redirect_count, misalign_error, exp_cnt);
    end
    tick();
  endtask

  task automatic test_jalr();
    ex_valid = 1; ex_is_jalr = 1; ex_pc = 32'h300; ex_rs1 = 32'h1001; ex_imm = 32'h3;
    push(1, 32'h1004, 4'b0011);
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if ({pc_w_enable, pc_data, flush_req, link_data} !== {e, 32'h304}) begin
      miscompares++; $display("FAIL jalr: got %h link %h want %h link 304", {pc_w_enable, pc_data, flush_req}, link_data, e);
    end
    tick(); exp_cnt++;
    ex_rs1 = 32'h1000; ex_imm = 32'h2;
    push(0, 32'h0, 4'h0);
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if ({pc_w_enable, pc_data, flush_req, misalign_error} !== {e, 1'b0}) begin
      miscompares++; $display("FAIL jalr_mis: got %h mis %b want %h mis 0", {pc_w_enable, pc_data, flush_req}, misalign_error, e);
    end
    tick(); clr();
    @(negedge clk); vectors++;
    if ({misalign_error, redirect_count} !== {1'b1, exp_cnt}) begin
      miscompares++; $display("FAIL mis_pulse: got %b/%h want 1/%h", misalign_error, redirect_count, exp_cnt);
    end
    tick();
    @(negedge clk); vectors++;
    if (misalign_error !== 1'b0) begin
      miscompares++; $display("FAIL mis_clear: got %b want 0", misalign_error);
    end
    tick();
  endtask

  task automatic test_pending();
    ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h1F0; ex_imm = 32'h10; pc_stall = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        ex_is_jal = 0; ex_is_jalr = 1; ex_is_branch = 1; ex_taken = 1;
        ex_rs1 = 32'h40 * (i + 1); ex_imm = 32'h8 * i; ex_pc = 32'h700 + i * 4;
        pc_stall = (i < 3);
      end
      push(1, 32'h200, 4'b0011);
      @(negedge clk);
      e = exp_q.pop_front(); vectors++;
      if ({pc_w_enable, pc_data, flush_req, redirect_count} !== {e, exp_cnt}) begin
        miscompares++; $display("FAIL hold_%0d: got %h/%h want %h/%h", i, {pc_w_enable, pc_data, flush_req}, redirect_count, e, exp_cnt);
      end
      tick();
    end
    exp_cnt++; clr();
    push(0, 32'h0, 4'h0);
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if ({pc_w_enable, pc_data, flush_req, redirect_count} !== {e, exp_cnt}) begin
      miscompares++; $display("FAIL hold_done: got %h/%h want %h/%h", {pc_w_enable, pc_data, flush_req}, redirect_count, e, exp_cnt);
    end
    tick();
  endtask

  task automatic test_trap_pending();
    ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h1F0; ex_imm = 32'h10; pc_stall = 1;
    tick(); clr(); pc_stall = 1;
    trap_valid = 1; trap_vector = 32'h80;
    push(1, 32'h80, 4'b0111);
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if ({pc_w_enable, pc_data, flush_req} !== e) begin
      miscompares++; $display("FAIL trap_override: got %h want %h", {pc_w_enable, pc_data, flush_req}, e);
    end
    tick(); trap_valid = 0; pc_stall = 0;
    push(1, 32'h80, 4'b0111);
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if ({pc_w_enable, pc_data, flush_req} !== e) begin
      miscompares++; $display("FAIL trap_consume: got %h want %h", {pc_w_enable, pc_data, flush_req}, e);
    end
    tick(); exp_cnt++;
    @(negedge clk); vectors++;
    if ({pc_w_enable, redirect_count} !== {1'b0, exp_cnt}) begin
      miscompares++; $display("FAIL trap_done: got %b/%h want 0/%h", pc_w_enable, redirect_count, exp_cnt);
    end
    tick();
  endtask

  task automatic test_priority();
    ex_valid = 1; ex_is_branch = 1; ex_taken = 1; ex_pc = 32'h100; ex_imm = 32'h20;
    trap_valid = 1; trap_vector = 32'hC0;
    push(1, 32'hC0, 4'b0111);
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if ({pc_w_enable, pc_data, flush_req} !== e) begin
      miscompares++; $display("FAIL trap_vs_br: got %h want %h", {pc_w_enable, pc_data, flush_req}, e);
    end
    tick(); exp_cnt++; trap_valid = 0;
    ex_is_jal = 1; ex_is_jalr = 1; ex_imm = 32'h40; ex_rs1 = 32'h3C8;
    push(1, 32'h408, 4'b0011);
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if ({pc_w_enable, pc_data, flush_req} !== e) begin
      miscompares++; $display("FAIL jalr_first: got %h want %h", {pc_w_enable, pc_data, flush_req}, e);
    end
    tick(); exp_cnt++; clr();
    @(negedge clk); vectors++;
    if (redirect_count !== exp_cnt) begin
      miscompares++; $display("FAIL prio_cnt: got %h want %h", redirect_count, exp_cnt);
    end
    tick();
  endtask

  task automatic test_reset_pending();
    ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h1F0; ex_imm = 32'h10; pc_stall = 1;
    tick(); clr(); pc_stall = 1; rst = 1;
    tick(); rst = 0; pc_stall = 0; exp_cnt = 0;
    push(0, 32'h0, 4'h0);
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if ({pc_w_enable, pc_data, flush_req, redirect_count} !== {e, exp_cnt}) begin
      miscompares++; $display("FAIL rst_pending: got %h/%h want %h/%h", {pc_w_enable, pc_data, flush_req}, redirect_count, e, exp_cnt);
    end
    tick();
  endtask

  task automatic test_wrap();
    ex_valid = 1; ex_is_branch = 1; ex_taken = 1; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'h10;
    push(1, 32'h0, 4'b0011);
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if ({pc_w_enable, pc_data, flush_req, link_data} !== {e, 32'hFFFF_FFF4}) begin
      miscompares++; $display("FAIL tgt_wrap: got %h link %h want %h", {pc_w_enable, pc_data, flush_req}, link_data, e);
    end
    tick(); exp_cnt++; clr(); ex_pc = 32'hFFFF_FFFC;
    @(negedge clk); vectors++;
    if (link_data !== 32'h0) begin
      miscompares++; $display("FAIL link_wrap: got %h want 0", link_data);
    end
    tick(); clr();
  endtask

  task automatic test_saturation();
    ex_valid = 1; ex_is_branch = 1; ex_taken = 1; ex_pc = 32'h100; ex_imm = 32'h20;
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
      exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
    end
    #1;
    push(1, 32'h120, 4'b0011);
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if ({pc_w_enable, pc_data, flush_req, redirect_count} !== {e, 16'hFFFF} || exp_cnt !== 16'hFFFF) begin
      miscompares++; $display("FAIL sat: got %h/%h want %h/ffff", {pc_w_enable, pc_data, flush_req}, redirect_count, e);
    end
    tick(); clr();
    @(negedge clk); vectors++;
    if (redirect_count !== 16'hFFFF) begin
      miscompares++; $display("FAIL sat_hold: got %h want ffff", redirect_count);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jalr();
    test_pending();
    test_trap_pending();
    test_priority();
    test_reset_pending();
    test_wrap();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
